// File: rtl/cache_fill_fsm_pkg.sv
// Shared definitions for the cache block fill controller: state encoding,
// block geometry and the fill/return counter limits.
package cache_fill_fsm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

    localparam int          BLOCK_WORDS       = 8;
    localparam logic [15:0] BLOCK_OFFSET_MASK = 16'hFFF0;

    // Counters run 0..BLOCK_WORDS and stop there, so they need one extra bit.
    localparam int                CNT_W    = 4;
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(BLOCK_WORDS);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BLOCK_WORDS - 1);

    localparam int CNT_ISSUE    = 0;
    localparam int CNT_RECV     = 1;
    localparam int NUM_COUNTERS = 2;

    function automatic logic [BLOCK_WORDS-1:0] word_onehot(input logic [2:0] idx);
        word_onehot = BLOCK_WORDS'(1) << idx;
    endfunction

endpackage

// File: rtl/cache_fill_fsm_dff.sv
// Generic register cell with write enable and asynchronous active-low clear.
module dff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wen,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_reg <= '0;
        end else if (wen) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/cache_fill_fsm_fill_counter.sv
// Saturating word counter used for both request issue and data return tracking.
module fill_counter
    import cache_fill_fsm_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_reg;

    // Clear wins over enable so a new fill always starts from word 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en && (count_reg != CNT_MAX)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss block fill: issues 8 word reads, writes each returning word into
// the data array and strobes the tag array with the final return.
module cache_fill_fsm #(
    parameter int MEM_LATENCY = 4,
    parameter int BLOCK_WORDS = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   miss_detected,
    input  logic [15:0]            miss_address,
    input  logic [15:0]            memory_data,
    input  logic                   memory_data_valid,
    output logic                   fsm_busy,
    output logic                   mem_read,
    output logic [15:0]            memory_address,
    output logic [15:0]            fill_block_addr,
    output logic                   write_data_array,
    output logic [BLOCK_WORDS-1:0] data_word_en,
    output logic [15:0]            data_out,
    output logic                   write_tag_array
);

    import cache_fill_fsm_pkg::*;

    // The FSM counts returns rather than cycles, so latency only has to be
    // sane; a block size other than the data array's is a configuration error.
    if (MEM_LATENCY < 1 || BLOCK_WORDS != cache_fill_fsm_pkg::BLOCK_WORDS) begin : g_unsupported_config
    end

    logic                   state_reg;
    fill_state_t            state;
    fill_state_t            state_next;
    logic [15:0]            fill_block_addr_reg;
    logic [NUM_COUNTERS-1:0] cnt_en;
    logic [CNT_W-1:0]       cnt_val [NUM_COUNTERS];
    logic [CNT_W-1:0]       issue_cnt;
    logic [CNT_W-1:0]       recv_cnt;
    logic                   start_fill;
    logic                   issue_en;
    logic                   issue_done;
    logic                   recv_en;
    logic                   last_return;
    logic [2:0]             issue_idx;

    assign state = fill_state_t'(state_reg);

    assign start_fill  = (state == IDLE) && miss_detected;
    assign issue_done  = (issue_cnt == CNT_MAX);
    assign issue_en    = (state == FILL) && !issue_done;
    assign recv_en     = (state == FILL) && memory_data_valid;
    assign last_return = recv_en && (recv_cnt == CNT_LAST);

    // A miss seen while filling is not latched; the stalled pipeline repeats it.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_fill)  state_next = FILL;
            FILL:    if (last_return) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    dff #(.WIDTH(1)) u_state_reg (
        .clk (clk),
        .rst (rst),
        .wen (1'b1),
        .d   (state_next),
        .q   (state_reg)
    );

    dff #(.WIDTH(16)) u_block_addr_reg (
        .clk (clk),
        .rst (rst),
        .wen (start_fill),
        .d   (miss_address & BLOCK_OFFSET_MASK),
        .q   (fill_block_addr_reg)
    );

    assign cnt_en[CNT_ISSUE] = issue_en;
    assign cnt_en[CNT_RECV]  = recv_en;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_COUNTERS; gi++) begin : g_counters
            fill_counter u_fill_counter (
                .clk   (clk),
                .rst   (rst),
                .clr   (start_fill),
                .en    (cnt_en[gi]),
                .count (cnt_val[gi])
            );
        end
    endgenerate

    assign issue_cnt = cnt_val[CNT_ISSUE];
    assign recv_cnt  = cnt_val[CNT_RECV];

    // Once all words are requested the address parks on the last word.
    assign issue_idx = issue_done ? 3'(BLOCK_WORDS - 1) : issue_cnt[2:0];

    assign fsm_busy         = (state == FILL);
    assign mem_read         = issue_en;
    assign memory_address   = fill_block_addr_reg + {12'b0, issue_idx, 1'b0};
    assign fill_block_addr  = fill_block_addr_reg;
    assign write_data_array = recv_en;
    assign data_word_en     = recv_en ? BLOCK_WORDS'(word_onehot(recv_cnt[2:0])) : '0;
    assign data_out         = recv_en ? memory_data : 16'h0000;
    assign write_tag_array  = last_return;

endmodule

// File: doc/cache_fill_fsm.md
CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 Parameter: MEM_LATENCY, default 4, cycles from mem_read issue to matching memory_data_valid; informational, the FSM counts returns, not cycles.
REQ-002 Parameter: BLOCK_WORDS, default 8, words per cache block, fixed to match the 8-word data-array block.
REQ-003 clk  input  1  single clock, all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; asserting low clears all state immediately.
REQ-005 miss_detected  input  1  level; a cache lookup missed this cycle.
REQ-006 miss_address  input  16  byte address of the missing access.
REQ-007 memory_data  input  16  word returned by main memory.
REQ-008 memory_data_valid  input  1  memory_data valid this cycle; returns arrive in request order.
REQ-009 fsm_busy  output  1  fill in progress; pipeline stalls while high.
REQ-010 mem_read  output  1  memory read request, one word per cycle.
REQ-011 memory_address  output  16  byte address of the current request.
REQ-012 fill_block_addr  output  16  latched block base address, used for block/tag decode.
REQ-013 write_data_array  output  1  write strobe to the data array.
REQ-014 data_word_en  output  8  one-hot word select for the data array, all-zero when not writing.
REQ-015 data_out  output  16  word to write, equal to memory_data.
REQ-016 write_tag_array  output  1  one-cycle strobe to write tag/valid for fill_block_addr.

Function
REQ-017 States: IDLE, FILL; 1-bit state register.
REQ-018 IDLE with miss_detected=1: latch fill_block_addr = miss_address & 16'hFFF0, clear issue_cnt and recv_cnt, next state FILL.
REQ-019 IDLE: fsm_busy=0, mem_read=0, write_data_array=0, write_tag_array=0, data_word_en=0; memory_data_valid ignored.
REQ-020 FILL: fsm_busy=1 every cycle, including the cycle write_tag_array fires.
REQ-021 FILL with issue_cnt<8: mem_read=1, memory_address = fill_block_addr + 2*issue_cnt, issue_cnt increments; after 8 issues mem_read=0 and memory_address holds its last value.
REQ-022 FILL with memory_data_valid=1: write_data_array=1, data_word_en = 1<<recv_cnt, data_out=memory_data (combinational, same cycle), recv_cnt increments.
REQ-023 FILL with memory_data_valid=1 and recv_cnt==7: write_tag_array=1 in the same cycle, next state IDLE.
REQ-024 Issue and receive proceed concurrently; a return in the same cycle as an issue is legal.
REQ-025 miss_detected during FILL is ignored; the miss is re-presented by the stalled pipeline after fsm_busy falls.
REQ-026 A new miss is accepted on the first IDLE cycle after completion; back-to-back fills have one IDLE cycle between them.
REQ-027 memory_data_valid beyond the 8th return in a fill is ignored (recv_cnt saturates, FSM already IDLE).
REQ-028 Counters are 4 bits, 0..8, no wrap.

Reset
REQ-029 rst low: state=IDLE, issue_cnt=0, recv_cnt=0, fill_block_addr=0; all outputs 0.
REQ-030 Reset mid-FILL aborts the fill; no write_tag_array is produced, and words already written stay in the array but are invalid by tag.
REQ-031 First rising edge after rst deasserts evaluates IDLE normally.

Structure
REQ-032 A shared package holds state encoding (IDLE=0, FILL=1), BLOCK_WORDS=8, and BLOCK_OFFSET_MASK=16'hFFF0.
REQ-033 One sub-module, fill_counter: 4-bit saturating counter with enable and synchronous clear, instantiated for issue and receive.
REQ-034 State and address registers are built from the codebase dff cell with wen.

Verification
REQ-035 Miss at 16'h1236, memory returns 4 cycles after each request -> mem_read addresses 1230,1232,...,123E on 8 consecutive cycles; data_word_en 01,02,...,80 on returns; write_tag_array with the 8th; fsm_busy high for 12 cycles.
REQ-036 Return data 16'hA000+i for word i -> data_out matches each word under the correct one-hot data_word_en.
REQ-037 miss_detected held high through FILL with address 16'h4000 -> ignored; next fill starts one cycle after completion at 16'h4000.
REQ-038 rst low after 3 returns -> all outputs 0 immediately, no tag write; a new miss at 16'h0010 fills cleanly with word_en starting at 01.
REQ-039 Gapped returns (valid on alternate cycles) -> words still written in order 01..80, tag written only with the 8th.
REQ-040 Spurious memory_data_valid in IDLE -> write_data_array and data_word_en stay 0.
